reg_file_mp: RTL and testbench
==============================

# reg_file_mp

Parametrised multi-port register file for the 16-bit MIPS datapath and its wider variants. It provides two combinational read ports and two write ports with defined write priority. Same-cycle write-to-read bypass removes the one-cycle write-back hazard, and a per-register busy scoreboard lets issue logic stall on outstanding producers such as cache-miss loads.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, is never busy; 0 = register 0 is ordinary

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- read_address_1  in  ADDR_W  read port 1 address
- read_address_2  in  ADDR_W  read port 2 address
- read_data_1  out  DATA_W  read port 1 data, combinational
- read_data_2  out  DATA_W  read port 2 data, combinational
- read_busy_1  out  1  scoreboard status of read_address_1, combinational
- read_busy_2  out  1  scoreboard status of read_address_2, combinational
- write_en_1  in  1  write port 1 enable (ALU write-back)
- write_address_1  in  ADDR_W  write port 1 address
- write_data_1  in  DATA_W  write port 1 data
- write_en_2  in  1  write port 2 enable (memory/load write-back)
- write_address_2  in  ADDR_W  write port 2 address
- write_data_2  in  DATA_W  write port 2 data
- busy_set_en  in  1  mark a register as having an outstanding producer
- busy_set_address  in  ADDR_W  register to mark busy

## Operation
- State: DEPTH x DATA_W data array; DEPTH-bit busy vector.
- Reset: on a rising edge with reset=1, all registers and busy bits clear to 0. Writes and busy_set are ignored that cycle.
- Reset output gating: while reset=1, read_data_* = 0 and read_busy_* = 0 regardless of other inputs. After reset, every read returns 0 and busy 0 until written or set.
- Write: each enabled port writes its data on the clock edge.
  - If both ports target the same address, port 2 wins.
  - With ZERO_REG=1, a write to address 0 is discarded.
- Read bypass (per read port), evaluated in priority order:
  - ZERO_REG=1 and address 0: data 0.
  - Else if write_en_2 and write_address_2 matches: write_data_2.
  - Else if write_en_1 and write_address_1 matches: write_data_1.
  - Else: the stored value.
- Busy update (next state), per register r:
  - busy_set_en with busy_set_address==r: set to 1. Set wins over a same-cycle clear.
  - Else any enabled write to r: clear to 0.
  - Else: hold.
  - Register 0 is never set when ZERO_REG=1.
- read_busy_x: the next-state busy bit of read_address_x, so it already reflects this cycle's writes and set. A register written this cycle reads not-busy with the bypassed data, unless it is also being set.
- Busy does not block writes: a write to a non-busy register is legal and simply stores.
- No arithmetic. Addresses are unsigned, full range 0..DEPTH-1 legal, no wrap handling needed.

## Timing
- Read latency: 0 cycles (combinational from address, write inputs and busy state).
- Write latency: visible to reads the same cycle via bypass; stored at the next rising edge.
- Busy set/clear: visible on read_busy the same cycle; registered at the next edge.
- Reset takes effect at the first rising edge with reset=1. Outputs are forced to 0 combinationally while reset is high.
- Reset asserted mid-operation (writes pending, busy bits set): everything clears on that edge; the pending writes are lost.
- No multi-cycle handshakes. All control is single-cycle strobes.

## Test plan
- Reset then read: after reset, read r0..r7 -> read_data 0 and read_busy 0 on both ports. With ZERO_REG=1, write 16'hFFFF to r0 -> r0 still reads 0.
- Bypass and store: write_en_1, r3 = 16'h1234 with read_address_1=3 in the same cycle -> read_data_1 = 16'h1234 that cycle. Next cycle, with no write, it still reads 16'h1234.
- Port conflict: both ports write r5 (port 1 = 16'hAAAA, port 2 = 16'h5555) -> same-cycle read = 16'h5555, stored value = 16'h5555.
- Scoreboard: busy_set r4 -> read_busy 1 that cycle and after. Two cycles later write_en_2 r4 = 16'h00C3 -> read_busy 0 and data 16'h00C3 that cycle. Repeat with busy_set and write on r4 in the same cycle -> busy stays 1, data stored.
- Reset mid-operation: r2 = 16'h7777 and r6 busy, then assert reset together with write_en_1 to r2 = 16'h1111 -> outputs 0 during reset. After release, r2 = 0 and r6 not busy.
- Parameter sweep: DATA_W=32, ADDR_W=5, ZERO_REG=0 -> write r0 = 32'hDEADBEEF and r31 = 32'h1 -> both read back; dual reads of r0/r31 are correct the same cycle.

Source files
------------

// File: rtl/reg_file_mp.sv
// Multi-port register file: two combinational read ports, two write ports,
// same-cycle write bypass and a per-register busy scoreboard.
module reg_file_mp #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_address_1,
  input  logic [ADDR_W-1:0] read_address_2,
  output logic [DATA_W-1:0] read_data_1,
  output logic [DATA_W-1:0] read_data_2,
  output logic              read_busy_1,
  output logic              read_busy_2,
  input  logic              write_en_1,
  input  logic [ADDR_W-1:0] write_address_1,
  input  logic [DATA_W-1:0] write_data_1,
  input  logic              write_en_2,
  input  logic [ADDR_W-1:0] write_address_2,
  input  logic [DATA_W-1:0] write_data_2,
  input  logic              busy_set_en,
  input  logic [ADDR_W-1:0] busy_set_address
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]  r_busy;
  logic [DEPTH-1:0]  w_busy_nxt;
  logic [DEPTH-1:0]  w_wr1;
  logic [DEPTH-1:0]  w_wr2;
  logic [DEPTH-1:0]  w_set;

  // One-hot write/set decode; register 0 is masked out when hardwired
  always_comb begin
    w_wr1 = '0;
    w_wr2 = '0;
    w_set = '0;
    if (write_en_1) w_wr1[write_address_1] = 1'b1;
    if (write_en_2) w_wr2[write_address_2] = 1'b1;
    if (busy_set_en) w_set[busy_set_address] = 1'b1;
    if (ZR) begin
      w_wr1[0] = 1'b0;
      w_wr2[0] = 1'b0;
      w_set[0] = 1'b0;
    end
  end

  // Set beats a same-cycle clear from either write port
  assign w_busy_nxt = w_set | (r_busy & ~(w_wr1 | w_wr2));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr2[i])      r_mem[i] <= write_data_2;
        else if (w_wr1[i]) r_mem[i] <= write_data_1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] f_read(
    input logic [ADDR_W-1:0] a,
    input logic              we1,
    input logic [ADDR_W-1:0] wa1,
    input logic [DATA_W-1:0] wd1,
    input logic              we2,
    input logic [ADDR_W-1:0] wa2,
    input logic [DATA_W-1:0] wd2,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] v;
    v = stored;
    if (ZR && a == '0)         v = '0;
    else if (we2 && wa2 == a)  v = wd2;
    else if (we1 && wa1 == a)  v = wd1;
    return v;
  endfunction

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  always_comb begin
    w_rd1 = f_read(read_address_1,
                   write_en_1, write_address_1, write_data_1,
                   write_en_2, write_address_2, write_data_2,
                   r_mem[read_address_1]);
    w_rd2 = f_read(read_address_2,
                   write_en_1, write_address_1, write_data_1,
                   write_en_2, write_address_2, write_data_2,
                   r_mem[read_address_2]);
  end

  assign read_data_1 = reset ? '0 : w_rd1;
  assign read_data_2 = reset ? '0 : w_rd2;
  assign read_busy_1 = !reset && w_busy_nxt[read_address_1];
  assign read_busy_2 = !reset && w_busy_nxt[read_address_2];

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: default 16x8 instance with hardwired r0
// and a 32x32 instance with an ordinary r0.
module tb_reg_file_mp;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // Instance A: DATA_W=16, ADDR_W=3, ZERO_REG=1
  logic [2:0]  a_ra1, a_ra2, a_wa1, a_wa2, a_bsa;
  logic [15:0] a_rd1, a_rd2, a_wd1, a_wd2;
  logic        a_rb1, a_rb2, a_we1, a_we2, a_bs;

  // Instance B: DATA_W=32, ADDR_W=5, ZERO_REG=0
  logic [4:0]  b_ra1, b_ra2, b_wa1, b_wa2, b_bsa;
  logic [31:0] b_rd1, b_rd2, b_wd1, b_wd2;
  logic        b_rb1, b_rb2, b_we1, b_we2, b_bs;

  reg_file_mp #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1)) u_a (
    .clock(clock), .reset(reset),
    .read_address_1(a_ra1), .read_address_2(a_ra2),
    .read_data_1(a_rd1), .read_data_2(a_rd2),
    .read_busy_1(a_rb1), .read_busy_2(a_rb2),
    .write_en_1(a_we1), .write_address_1(a_wa1), .write_data_1(a_wd1),
    .write_en_2(a_we2), .write_address_2(a_wa2), .write_data_2(a_wd2),
    .busy_set_en(a_bs), .busy_set_address(a_bsa)
  );

  reg_file_mp #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_b (
    .clock(clock), .reset(reset),
    .read_address_1(b_ra1), .read_address_2(b_ra2),
    .read_data_1(b_rd1), .read_data_2(b_rd2),
    .read_busy_1(b_rb1), .read_busy_2(b_rb2),
    .write_en_1(b_we1), .write_address_1(b_wa1), .write_data_1(b_wd1),
    .write_en_2(b_we2), .write_address_2(b_wa2), .write_data_2(b_wd2),
    .busy_set_en(b_bs), .busy_set_address(b_bsa)
  );

  typedef struct {
    bit          dut;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic exp(input bit dut, input int port, input logic [31:0] d,
                     input logic b, input string n);
    exp_t e;
    e.dut = dut; e.port = port; e.data = d; e.busy = b; e.name = n;
    q.push_back(e);
  endtask

  task automatic idle();
    a_we1 = 0; a_we2 = 0; a_bs = 0;
    a_wa1 = 0; a_wa2 = 0; a_bsa = 0; a_wd1 = 0; a_wd2 = 0;
    a_ra1 = 0; a_ra2 = 0;
    b_we1 = 0; b_we2 = 0; b_bs = 0;
    b_wa1 = 0; b_wa2 = 0; b_bsa = 0; b_wd1 = 0; b_wd2 = 0;
    b_ra1 = 0; b_ra2 = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Monitor: outputs are combinational, so they are sampled mid-cycle
  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] ad;
      logic        ab;
      e = q.pop_front();
      if (e.dut == 0) begin
        ad = (e.port == 1) ? {16'h0, a_rd1} : {16'h0, a_rd2};
        ab = (e.port == 1) ? a_rb1 : a_rb2;
      end else begin
        ad = (e.port == 1) ? b_rd1 : b_rd2;
        ab = (e.port == 1) ? b_rb1 : b_rb2;
      end
      tests++;
      if (ad !== e.data || ab !== e.busy) begin
        fails++;
        $display("FAIL %s: got data=%h busy=%b, expected data=%h busy=%b",
                 e.name, ad, ab, e.data, e.busy);
      end
    end
  end

  initial begin
    idle();
    reset = 1;
    tick();
    // Reset gating with a write attempt and busy set in flight
    a_we1 = 1; a_wa1 = 2; a_wd1 = 16'hFFFF; a_ra1 = 2;
    a_bs = 1; a_bsa = 2; a_ra2 = 2;
    b_we1 = 1; b_wa1 = 7; b_wd1 = 32'h1234_5678; b_ra1 = 7;
    exp(0, 1, 0, 0, "rst_gate_a1");
    exp(0, 2, 0, 0, "rst_gate_a2");
    exp(1, 1, 0, 0, "rst_gate_b1");
    tick();
    reset = 0;
    idle();

    for (int r = 0; r < 8; r++) begin
      idle();
      a_ra1 = 3'(r); a_ra2 = 3'(r);
      exp(0, 1, 0, 0, $sformatf("post_rst_p1_r%0d", r));
      exp(0, 2, 0, 0, $sformatf("post_rst_p2_r%0d", r));
      tick();
    end

    // Hardwired r0
    idle();
    a_we1 = 1; a_wa1 = 0; a_wd1 = 16'hFFFF; a_ra1 = 0; a_bs = 1; a_bsa = 0;
    exp(0, 1, 0, 0, "r0_write_same");
    tick();
    idle();
    exp(0, 1, 0, 0, "r0_write_next");
    tick();

    // Bypass then stored
    idle();
    a_we1 = 1; a_wa1 = 3; a_wd1 = 16'h1234; a_ra1 = 3;
    exp(0, 1, 16'h1234, 0, "bypass_r3");
    tick();
    idle();
    a_ra1 = 3; a_ra2 = 3;
    exp(0, 1, 16'h1234, 0, "stored_r3_p1");
    exp(0, 2, 16'h1234, 0, "stored_r3_p2");
    tick();

    // Port conflict: port 2 wins
    idle();
    a_we1 = 1; a_wa1 = 5; a_wd1 = 16'hAAAA;
    a_we2 = 1; a_wa2 = 5; a_wd2 = 16'h5555;
    a_ra1 = 5; a_ra2 = 5;
    exp(0, 1, 16'h5555, 0, "conflict_byp_p1");
    exp(0, 2, 16'h5555, 0, "conflict_byp_p2");
    tick();
    idle();
    a_ra1 = 5;
    exp(0, 1, 16'h5555, 0, "conflict_stored");
    tick();

    // Scoreboard on r4
    idle();
    a_bs = 1; a_bsa = 4; a_ra2 = 4;
    exp(0, 2, 0, 1, "busy_set_same");
    tick();
    idle();
    a_ra2 = 4; a_ra1 = 3;
    exp(0, 2, 0, 1, "busy_hold");
    exp(0, 1, 16'h1234, 0, "other_not_busy");
    tick();
    idle();
    a_we2 = 1; a_wa2 = 4; a_wd2 = 16'h00C3; a_ra2 = 4;
    exp(0, 2, 16'h00C3, 0, "busy_clear_byp");
    tick();
    idle();
    a_ra2 = 4;
    exp(0, 2, 16'h00C3, 0, "busy_cleared");
    tick();
    idle();
    a_bs = 1; a_bsa = 4; a_we1 = 1; a_wa1 = 4; a_wd1 = 16'h0055;
    a_ra1 = 4;
    exp(0, 1, 16'h0055, 1, "set_beats_clear");
    tick();
    idle();
    a_ra1 = 4;
    exp(0, 1, 16'h0055, 1, "set_wins_stored");
    tick();

    // Reset mid-operation
    idle();
    a_we1 = 1; a_wa1 = 2; a_wd1 = 16'h7777; a_bs = 1; a_bsa = 6;
    tick();
    idle();
    a_ra1 = 2; a_ra2 = 6;
    exp(0, 1, 16'h7777, 0, "pre_rst_r2");
    exp(0, 2, 0, 1, "pre_rst_r6_busy");
    tick();
    idle();
    reset = 1;
    a_we1 = 1; a_wa1 = 2; a_wd1 = 16'h1111; a_ra1 = 2; a_ra2 = 6;
    exp(0, 1, 0, 0, "mid_rst_r2");
    exp(0, 2, 0, 0, "mid_rst_r6");
    tick();
    reset = 0;
    idle();
    a_ra1 = 2; a_ra2 = 6;
    exp(0, 1, 0, 0, "after_rst_r2");
    exp(0, 2, 0, 0, "after_rst_r6");
    tick();

    // Wide instance with ordinary r0
    idle();
    b_we1 = 1; b_wa1 = 0;  b_wd1 = 32'hDEADBEEF;
    b_we2 = 1; b_wa2 = 31; b_wd2 = 32'h1;
    b_ra1 = 0; b_ra2 = 31;
    exp(1, 1, 32'hDEADBEEF, 0, "wide_byp_r0");
    exp(1, 2, 32'h1, 0, "wide_byp_r31");
    tick();
    idle();
    b_ra1 = 31; b_ra2 = 0;
    exp(1, 1, 32'h1, 0, "wide_stored_r31");
    exp(1, 2, 32'hDEADBEEF, 0, "wide_stored_r0");
    tick();
    idle();
    b_bs = 1; b_bsa = 0; b_ra1 = 0; b_ra2 = 7;
    exp(1, 1, 32'hDEADBEEF, 1, "wide_r0_busy");
    exp(1, 2, 0, 0, "wide_r7_untouched");
    tick();
    idle();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clock);
    if (q.size() > 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
